// File: rtl/countdown_timer_pkg.sv
`default_nettype none
// ============================================================================
// countdown_timer_pkg : shared state enum, BCD digit type and digit limits
// Revision 1.0 : initial release
// ============================================================================
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t MIN_TENS_MAX = 4'd5;

endpackage
`default_nettype wire

// File: rtl/countdown_timer_sec_prescaler.sv
`default_nettype none
// ============================================================================
// sec_prescaler : divides clk into one-cycle second and half-second pulses
// Revision 1.0 : initial release
// ============================================================================
module sec_prescaler #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic sec_tick,
  output logic half_tick
);

  localparam int            c_W    = $clog2(TICKS_PER_SEC);
  localparam logic [c_W-1:0] c_LAST = c_W'(TICKS_PER_SEC - 1);
  localparam logic [c_W-1:0] c_HALF = c_W'(TICKS_PER_SEC / 2 - 1);

  logic [c_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign sec_tick  = enable && (r_cnt == c_LAST);
  assign half_tick = enable && ((r_cnt == c_LAST) || (r_cnt == c_HALF));

endmodule
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// countdown_timer : BCD MM:SS countdown with preset edit, pause and expiry flash
// Revision 1.0 : initial release
// ============================================================================
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_mode,
  input  logic       btn_min,
  input  logic       btn_sec,
  input  logic       btn_start,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       expired,
  output logic       flash
);

  // Two-digit BCD increment wrapping {tens_max,9} back to 00, no carry out.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input bcd_t tens_max);
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == tens_max) return 8'h00;
      return {v[7:4] + 4'd1, 4'd0};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [15:0] dec_time(input logic [15:0] t);
    bcd_t mt, mo, st, so;
    {mt, mo, st, so} = t;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = SEC_TENS_MAX;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  state_t      r_state, w_state_nxt;
  logic [15:0] r_time, w_time_nxt;
  logic [15:0] r_preset, w_preset_nxt;
  logic [15:0] w_dec;
  logic        r_flash, w_flash_nxt;
  logic        r_running, r_expired;
  logic        w_zero, w_sec_tick, w_half_tick, w_enable, w_clear;

  assign w_zero   = (r_time == 16'h0000);
  assign w_enable = (r_state == ST_RUN) || (r_state == ST_EXPIRED);
  // Any state entry restarts the second, so pause/resume discards partial seconds.
  assign w_clear  = (w_state_nxt != r_state) || !w_enable;

  sec_prescaler #(
    .TICKS_PER_SEC (TICKS_PER_SEC)
  ) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .enable    (w_enable),
    .clear     (w_clear),
    .sec_tick  (w_sec_tick),
    .half_tick (w_half_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_time    <= '0;
      r_preset  <= '0;
      r_flash   <= 1'b0;
      r_running <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_time    <= w_time_nxt;
      r_preset  <= w_preset_nxt;
      r_flash   <= w_flash_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      r_expired <= (w_state_nxt == ST_EXPIRED);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_time_nxt   = r_time;
    w_preset_nxt = r_preset;
    w_flash_nxt  = 1'b0;
    w_dec        = dec_time(r_time);
    case (r_state)
      ST_IDLE, ST_PAUSE: begin
        if (btn_start) begin
          if (!w_zero) begin
            w_state_nxt = ST_RUN;
            if (r_state == ST_IDLE) w_preset_nxt = r_time;
          end
        end else if (set_mode) begin
          if (btn_min) w_time_nxt[15:8] = bcd_inc(r_time[15:8], MIN_TENS_MAX);
          if (btn_sec) w_time_nxt[7:0]  = bcd_inc(r_time[7:0], SEC_TENS_MAX);
        end
      end
      ST_RUN: begin
        if (btn_start) begin
          w_state_nxt = ST_PAUSE;
        end else if (w_sec_tick) begin
          w_time_nxt = w_dec;
          if (w_dec == 16'h0000) begin
            w_state_nxt = ST_EXPIRED;
            w_flash_nxt = 1'b1;
          end
        end
      end
      ST_EXPIRED: begin
        w_flash_nxt = r_flash;
        if (btn_start || btn_min || btn_sec) begin
          w_time_nxt  = r_preset;
          w_state_nxt = ST_IDLE;
          w_flash_nxt = 1'b0;
        end else if (w_half_tick) begin
          w_flash_nxt = ~r_flash;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign {min_tens, min_ones, sec_tens, sec_ones} = r_time;
  assign running = r_running;
  assign expired = r_expired;
  assign flash   = r_flash;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
// tb_countdown_timer : directed scoreboard bench, TICKS_PER_SEC = 10
// Revision 1.0 : initial release
// ============================================================================
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       set_mode = 1'b0;
    logic       btn_min = 1'b0;
    logic       btn_sec = 1'b0;
    logic       btn_start = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, expired, flash;

    typedef struct {
        string       name;
        logic [18:0] val;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    countdown_timer #(.TICKS_PER_SEC(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .set_mode  (set_mode),
        .btn_min   (btn_min),
        .btn_sec   (btn_sec),
        .btn_start (btn_start),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .running   (running),
        .expired   (expired),
        .flash     (flash)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are observed on the falling edge, away from the active edge.
    always @(negedge clk) begin
        logic [18:0] got;
        exp_t        e;
        got = {min_tens, min_ones, sec_tens, sec_ones, running, expired, flash};
        while (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got time=%h run/exp/flash=%b required time=%h run/exp/flash=%b",
                         e.name, got[18:3], got[2:0], e.val[18:3], e.val[2:0]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic s, input logic m, input logic c);
        btn_start = s; btn_min = m; btn_sec = c;
        @(posedge clk);
        #1;
        btn_start = 1'b0; btn_min = 1'b0; btn_sec = 1'b0;
    endtask

    task automatic preset(input int m, input int s);
        set_mode = 1'b1;
        repeat (m) pulse(1'b0, 1'b1, 1'b0);
        repeat (s) pulse(1'b0, 1'b0, 1'b1);
        set_mode = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic chk(input string name, input logic [15:0] t,
                       input logic run, input logic ex, input logic fl);
        exp_t e;
        e.name = name;
        e.val  = {t, run, ex, fl};
        q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic chk_now(input string name, input logic [18:0] v);
        logic [18:0] got;
        got = {min_tens, min_ones, sec_tens, sec_ones, running, expired, flash};
        checks++;
        if (got !== v) begin
            errors++;
            $display("FAIL %s: got time=%h run/exp/flash=%b required time=%h run/exp/flash=%b",
                     name, got[18:3], got[2:0], v[18:3], v[2:0]);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [15:0] borrow_exp [3];
        int          borrow_min [3];
        borrow_min[0] = 1;  borrow_exp[0] = 16'h0059;
        borrow_min[1] = 9;  borrow_exp[1] = 16'h0859;
        borrow_min[2] = 10; borrow_exp[2] = 16'h0959;

        tick(2);
        rst = 1'b0;
        tick(1);
        chk_now("reset_direct", 19'h0);
        chk("reset_state", 16'h0000, 0, 0, 0);

        preset(2, 5);
        chk("preset_0205", 16'h0205, 0, 0, 0);
        pulse(1'b1, 1'b0, 1'b0);
        chk("start_running", 16'h0205, 1, 0, 0);
        tick(10);
        chk("first_dec", 16'h0204, 1, 0, 0);
        tick(60);
        chk("dec_0158", 16'h0158, 1, 0, 0);
        set_mode = 1'b1;
        pulse(1'b0, 1'b1, 1'b1);
        set_mode = 1'b0;
        chk("edit_ignored_run", 16'h0158, 1, 0, 0);

        for (int i = 0; i < 3; i++) begin
            do_reset();
            preset(borrow_min[i], 0);
            pulse(1'b1, 1'b0, 1'b0);
            tick(10);
            chk($sformatf("borrow_%0d", i), borrow_exp[i], 1, 0, 0);
        end

        do_reset();
        preset(0, 2);
        pulse(1'b1, 1'b0, 1'b0);
        tick(10);
        chk("exp_0001", 16'h0001, 1, 0, 0);
        tick(10);
        chk("expired_entry", 16'h0000, 0, 1, 1);
        tick(4);
        chk("flash_hold", 16'h0000, 0, 1, 1);
        tick(1);
        chk("flash_toggle1", 16'h0000, 0, 1, 0);
        tick(5);
        chk("flash_toggle2", 16'h0000, 0, 1, 1);
        pulse(1'b0, 1'b0, 1'b1);
        chk("reload_idle", 16'h0002, 0, 0, 0);

        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        chk("start_zero_ignored", 16'h0000, 0, 0, 0);
        preset(3, 59);
        chk("sec_59", 16'h0359, 0, 0, 0);
        preset(0, 1);
        chk("sec_wrap_no_carry", 16'h0300, 0, 0, 0);

        do_reset();
        preset(3, 30);
        pulse(1'b1, 1'b0, 1'b0);
        tick(7);
        pulse(1'b1, 1'b0, 1'b0);
        chk("pause_hold", 16'h0330, 0, 0, 0);
        tick(15);
        chk("pause_still", 16'h0330, 0, 0, 0);
        pulse(1'b1, 1'b0, 1'b0);
        tick(9);
        chk("resume_no_dec_yet", 16'h0330, 1, 0, 0);
        tick(1);
        chk("resume_dec", 16'h0329, 1, 0, 0);
        pulse(1'b1, 1'b0, 1'b0);
        preset(57, 31);
        chk("pause_edit_zero", 16'h0000, 0, 0, 0);
        pulse(1'b1, 1'b0, 1'b0);
        chk("resume_zero_blocked", 16'h0000, 0, 0, 0);

        do_reset();
        preset(1, 0);
        pulse(1'b1, 1'b0, 1'b0);
        tick(13);
        #1;
        rst = 1'b1;
        #1;
        chk_now("async_rst_direct", 19'h0);
        chk("async_rst", 16'h0000, 0, 0, 0);
        rst = 1'b0;
        tick(1);
        preset(0, 5);
        set_mode = 1'b1;
        pulse(1'b1, 1'b1, 1'b0);
        set_mode = 1'b0;
        chk("start_drops_edit", 16'h0005, 1, 0, 0);
        tick(10);
        chk("after_start_edit", 16'h0004, 1, 0, 0);

        tick(2);
        if (errors != 0 || checks < 12) begin
            $display("FAIL summary: %0d checks, %0d errors", checks, errors);
        end else begin
            $display("PASS summary: %0d checks, %0d errors", checks, errors);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
